// File: rtl/pipeline_ctrl_pkg.sv
// rtl/pipeline_ctrl_pkg.sv - shared CPU constants: controller state encoding and decode opcodes
package pipeline_ctrl_pkg;

    typedef enum logic {
        ST_RUN     = 1'b0,
        ST_MD_BUSY = 1'b1
    } md_state_t;

    localparam logic [4:0] OP_ADD  = 5'b00000;
    localparam logic [4:0] OP_ADDI = 5'b00101;
    localparam logic [4:0] OP_LW   = 5'b01000;
    localparam logic [4:0] OP_SW   = 5'b00111;
    localparam logic [4:0] OP_JAL  = 5'b00011;
    localparam logic [4:0] OP_SETX = 5'b10101;

endpackage

// File: rtl/pipeline_ctrl_hazard_cmp.sv
// rtl/pipeline_ctrl_hazard_cmp.sv - producer rd vs consumer rs/rt match, r0 never counts as a write
module hazard_cmp (
    input  logic       wr_en,
    input  logic [4:0] rd,
    input  logic [4:0] rs,
    input  logic [4:0] rt,
    input  logic       use_rs,
    input  logic       use_rt,
    output logic       hit
);

    assign hit = wr_en && (rd != 5'd0) &&
                 ((use_rs && (rs == rd)) || (use_rt && (rt == rd)));

endmodule

// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - stall/flush/bubble control with load-use detection and multi-cycle mult-div hold
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int MD_LATENCY = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [4:0] d_rs,
    input  logic [4:0] d_rt,
    input  logic [4:0] d_rd,
    input  logic       d_uses_rs,
    input  logic       d_uses_rt,
    input  logic       d_we,
    input  logic       d_lw,
    input  logic       d_md,
    input  logic       x_br_taken,
    output logic       stall_f,
    output logic       stall_d,
    output logic       hold_x,
    output logic       bubble_x,
    output logic       bubble_m,
    output logic       flush_fd,
    output logic       flush_dx,
    output logic       md_busy,
    output logic       md_done
);

    localparam logic [4:0] MD_LOAD = 5'(MD_LATENCY - 1);

    md_state_t  state;
    logic [4:0] count;

    logic       x_v, x_we, x_lw, x_md;
    logic [4:0] x_rd;
    logic       m_v, m_we;
    logic [4:0] m_rd;

    logic load_use;
    logic md_issue;

    hazard_cmp u_x_cmp (
        .wr_en  (x_v && x_we && x_lw),
        .rd     (x_rd),
        .rs     (d_rs),
        .rt     (d_rt),
        .use_rs (d_uses_rs),
        .use_rt (d_uses_rt),
        .hit    (load_use)
    );

    // Outputs are also gated by reset so they read 0 while reset is held, whatever the inputs do.
    always_comb begin
        stall_f  = 1'b0;
        stall_d  = 1'b0;
        hold_x   = 1'b0;
        bubble_x = 1'b0;
        bubble_m = 1'b0;
        flush_fd = 1'b0;
        flush_dx = 1'b0;
        md_busy  = 1'b0;
        md_done  = 1'b0;
        if (reset) begin
            if (state == ST_MD_BUSY) begin
                if (count != 5'd0) begin
                    stall_f  = 1'b1;
                    stall_d  = 1'b1;
                    hold_x   = 1'b1;
                    bubble_m = 1'b1;
                    md_busy  = 1'b1;
                end else begin
                    md_done  = 1'b1;
                end
            end else if (x_br_taken) begin
                flush_fd = 1'b1;
                flush_dx = 1'b1;
            end else if (load_use) begin
                stall_f  = 1'b1;
                stall_d  = 1'b1;
                bubble_x = 1'b1;
            end
        end
    end

    assign md_issue = (state == ST_RUN) && d_md && !x_br_taken && !load_use;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= ST_RUN;
            count <= 5'd0;
            x_v   <= 1'b0;
            x_rd  <= 5'd0;
            x_we  <= 1'b0;
            x_lw  <= 1'b0;
            x_md  <= 1'b0;
            m_v   <= 1'b0;
            m_rd  <= 5'd0;
            m_we  <= 1'b0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (md_issue) begin
                        state <= ST_MD_BUSY;
                        count <= MD_LOAD;
                    end
                end
                ST_MD_BUSY: begin
                    if (count == 5'd0) begin
                        state <= ST_RUN;
                    end else begin
                        count <= count - 5'd1;
                    end
                end
                default: state <= ST_RUN;
            endcase

            if (hold_x) begin
                m_v <= 1'b0;
            end else begin
                x_v  <= !(bubble_x || flush_dx);
                x_rd <= d_rd;
                x_we <= d_we;
                x_lw <= d_lw;
                x_md <= d_md;
                m_v  <= x_v && !bubble_m;
                m_rd <= x_rd;
                m_we <= x_we;
            end
        end
    end

endmodule
